mainfsm: RTL and testbench
==========================

# mainfsm

Multicycle main control FSM for the ARM core's control unit. It sits directly upstream of the conditional-logic stage: it sequences each instruction through fetch, decode, execute, memory and writeback. Per cycle it produces the unconditional write requests (RegW, MemW, Branch) that the conditional logic gates with CondEx, plus the datapath mux selects and the IR/PC enables. It is a Moore machine with one memory-ready handshake input.

## Interface
- No parameters; all encodings come from the shared package.
- clk  in  1  system clock, rising-edge.
- reset  in  1  synchronous, active-high; one clock, synchronous active-high reset.
- Op  in  2  instruction bits [27:26]: 00 data-processing, 01 memory, 10 branch, 11 undefined.
- Funct  in  6  instruction bits [25:20]; Funct[5] is I (immediate), Funct[0] is S/L (load when 1 for memory ops).
- MemRdy  in  1  memory completes the current access this cycle.
- IRWrite  out  1  load instruction register.
- NextPC  out  1  unconditional PC write (PC+4).
- AdrSrc  out  1  memory address select: 0 PC, 1 ALU result.
- ALUSrcA  out  1  0 register A, 1 PC.
- ALUSrcB  out  2  00 register B, 01 extended immediate, 10 constant 4.
- ResultSrc  out  2  00 ALUOut, 01 Data, 10 ALU result.
- ALUOp  out  1  1 ALU decoder uses Funct, 0 forces ADD.
- RegW  out  1  register write request to condlogic.
- MemW  out  1  memory write request to condlogic.
- Branch  out  1  PC-from-branch request (PCS) to condlogic.
- Undef  out  1  one-cycle pulse when an undefined Op is decoded.

## Operation
- States: FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXECR, EXECI, ALUWB, BRANCH, UNDEF.
- Transitions:
  - FETCH goes to DECODE when MemRdy=1; otherwise it holds.
  - DECODE: Op=01 goes to MEMADR; Op=00 with Funct[5]=0 goes to EXECR; Op=00 with Funct[5]=1 goes to EXECI; Op=10 goes to BRANCH; Op=11 goes to UNDEF.
  - MEMADR: Funct[0]=1 goes to MEMRD; otherwise MEMWR.
  - MEMRD goes to MEMWB when MemRdy=1; otherwise it holds.
  - MEMWR goes to FETCH when MemRdy=1; otherwise it holds.
  - MEMWB, ALUWB, BRANCH and UNDEF go to FETCH.
  - EXECR and EXECI go to ALUWB.
- Outputs are decoded from state only. MemRdy affects only IRWrite and NextPC. Unlisted outputs are 0 (no x).
  - FETCH: AdrSrc=0, ALUSrcA=1, ALUSrcB=10, ALUOp=0, ResultSrc=10. IRWrite=NextPC=MemRdy.
  - DECODE: ALUSrcA=1, ALUSrcB=10, ResultSrc=10 (PC+8 read).
  - MEMADR and EXECI: ALUSrcA=0, ALUSrcB=01. ALUOp is 0 in MEMADR and 1 in EXECI.
  - EXECR: ALUSrcA=0, ALUSrcB=00, ALUOp=1.
  - MEMRD: AdrSrc=1.
  - MEMWR: AdrSrc=1, MemW=1 for every cycle in the state.
  - MEMWB: ResultSrc=01, RegW=1.
  - ALUWB: ResultSrc=00, RegW=1.
  - BRANCH: ALUSrcA=0, ALUSrcB=01, ResultSrc=10, Branch=1.
  - UNDEF: Undef=1; all write requests 0.
- Op and Funct are sampled in DECODE and MEMADR only. The IR holds them stable from the cycle after FETCH completes.
- Reset:
  - While reset=1, the outputs IRWrite, NextPC, RegW, MemW, Branch and Undef are forced to 0 combinationally.
  - The state register loads FETCH on the first edge with reset=1, whatever the current state. This includes mid-MEMWR: MemW drops in the same cycle reset rises.
  - After reset deasserts, the outputs equal the FETCH values.
- Unencoded state values (illegal encodings) go to FETCH on the next edge with all write requests 0.

## Timing
- One state transition per rising clk edge. No output register, so select and enable outputs change right after the edge.
- Instruction latencies with MemRdy tied to 1:
  - Load: 5 cycles.
  - Store: 4 cycles.
  - Data-processing: 4 cycles.
  - Branch: 3 cycles.
  - Undefined Op: 3 cycles.
- Each MemRdy=0 cycle in FETCH, MEMRD or MEMWR adds exactly one cycle.
- RegW, MemW and Branch reach condlogic in the same cycle. Gating happens downstream; this block never sees CondEx.
- A MemRdy pulse outside FETCH, MEMRD and MEMWR is ignored.

## Structure
- Shared package arm_ctrl_pkg holds:
  - the state enum typedef statetype;
  - the Op constants OP_DP, OP_MEM, OP_B;
  - the ALUSrcB constants SRCB_REG, SRCB_IMM, SRCB_4;
  - the ResultSrc constants RES_ALUOUT, RES_DATA, RES_ALU.
- The state register reuses the existing synchronous-reset flop (flopr, width of statetype).
- One sub-module: mainfsm_dec, a combinational state-to-control-word decoder. The next-state logic stays in mainfsm.

## Test plan
- Reset, then Op=00, Funct=6'b000000, MemRdy=1 -> state sequence FETCH, DECODE, EXECR, ALUWB, FETCH. ALUOp=1 only in EXECR; RegW=1 only in ALUWB.
- Op=01, Funct[0]=1, with MemRdy=0 for 2 cycles in MEMRD -> sequence FETCH, DECODE, MEMADR, MEMRD, MEMRD, MEMRD, MEMWB, which is 7 cycles. AdrSrc=1 throughout MEMRD; RegW=1 with ResultSrc=01 in MEMWB.
- Op=01, Funct[0]=0, MemRdy=1 -> MemW=1 for exactly 1 cycle in MEMWR with AdrSrc=1, then FETCH.
- Op=10 -> Branch=1 for 1 cycle with ALUSrcB=01; NextPC=1 only in the FETCH cycle; total 3 cycles.
- Op=11 -> Undef pulse of exactly 1 cycle; RegW, MemW and Branch stay 0; then FETCH.
- Assert reset for 1 cycle while in MEMWR with MemW=1 -> MemW=0 in that cycle; next state FETCH; IRWrite=0 until reset deasserts.

Source files
------------

// File: rtl/arm_ctrl_pkg.sv
// Shared encodings for the ARM multicycle control unit:
// FSM states, datapath select constants and the decoded control word.
package arm_ctrl_pkg;

   typedef enum logic [3:0] {
      FETCH  = 4'd0,
      DECODE = 4'd1,
      MEMADR = 4'd2,
      MEMRD  = 4'd3,
      MEMWB  = 4'd4,
      MEMWR  = 4'd5,
      EXECR  = 4'd6,
      EXECI  = 4'd7,
      ALUWB  = 4'd8,
      BRANCH = 4'd9,
      UNDEF  = 4'd10
   } statetype;

   localparam logic [1:0] OP_DP  = 2'b00;
   localparam logic [1:0] OP_MEM = 2'b01;
   localparam logic [1:0] OP_B   = 2'b10;

   localparam logic [1:0] SRCB_REG = 2'b00;
   localparam logic [1:0] SRCB_IMM = 2'b01;
   localparam logic [1:0] SRCB_4   = 2'b10;

   localparam logic [1:0] RES_ALUOUT = 2'b00;
   localparam logic [1:0] RES_DATA   = 2'b01;
   localparam logic [1:0] RES_ALU    = 2'b10;

   // fetch marks the state where IRWrite/NextPC follow MemRdy
   typedef struct packed {
      logic       fetch;
      logic       adr_src;
      logic       alu_src_a;
      logic [1:0] alu_src_b;
      logic [1:0] result_src;
      logic       alu_op;
      logic       reg_w;
      logic       mem_w;
      logic       branch;
      logic       undef;
   } ctrl_t;

endpackage

// File: rtl/flopr.sv
// Resettable register; synchronous active-high reset clears to zero.
module flopr #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   always_ff @(posedge clk) begin
      if (reset) q <= '0;
      else       q <= d;
   end

endmodule

// File: rtl/mainfsm_dec.sv
// State-to-control-word decoder for the main FSM (Moore outputs).
module mainfsm_dec
   import arm_ctrl_pkg::*;
(
   input  statetype state,
   output ctrl_t    ctrl
);

   always_comb begin
      ctrl = '0;
      case (state)
         FETCH: begin
            ctrl.fetch      = 1'b1;
            ctrl.alu_src_a  = 1'b1;
            ctrl.alu_src_b  = SRCB_4;
            ctrl.result_src = RES_ALU;
         end
         DECODE: begin
            ctrl.alu_src_a  = 1'b1;
            ctrl.alu_src_b  = SRCB_4;
            ctrl.result_src = RES_ALU;
         end
         MEMADR: begin
            ctrl.alu_src_b  = SRCB_IMM;
         end
         EXECI: begin
            ctrl.alu_src_b  = SRCB_IMM;
            ctrl.alu_op     = 1'b1;
         end
         EXECR: begin
            ctrl.alu_src_b  = SRCB_REG;
            ctrl.alu_op     = 1'b1;
         end
         MEMRD: begin
            ctrl.adr_src    = 1'b1;
         end
         MEMWR: begin
            ctrl.adr_src    = 1'b1;
            ctrl.mem_w      = 1'b1;
         end
         MEMWB: begin
            ctrl.result_src = RES_DATA;
            ctrl.reg_w      = 1'b1;
         end
         ALUWB: begin
            ctrl.result_src = RES_ALUOUT;
            ctrl.reg_w      = 1'b1;
         end
         BRANCH: begin
            ctrl.alu_src_b  = SRCB_IMM;
            ctrl.result_src = RES_ALU;
            ctrl.branch     = 1'b1;
         end
         UNDEF: begin
            ctrl.undef      = 1'b1;
         end
         default: ctrl = '0;
      endcase
   end

endmodule

// File: rtl/mainfsm.sv
// Multicycle main control FSM: sequences fetch, decode, execute,
// memory and writeback, issuing unconditional write requests.
module mainfsm
   import arm_ctrl_pkg::*;
(
   input  logic       clk,
   input  logic       reset,
   input  logic [1:0] Op,
   input  logic [5:0] Funct,
   input  logic       MemRdy,
   output logic       IRWrite,
   output logic       NextPC,
   output logic       AdrSrc,
   output logic       ALUSrcA,
   output logic [1:0] ALUSrcB,
   output logic [1:0] ResultSrc,
   output logic       ALUOp,
   output logic       RegW,
   output logic       MemW,
   output logic       Branch,
   output logic       Undef
);

   localparam int SW = $bits(statetype);

   statetype      state;
   statetype      state_next;
   logic [SW-1:0] state_q;
   logic [SW-1:0] state_d;
   ctrl_t         ctrl;
   logic          funct_unused;

   assign funct_unused = ^Funct[4:1];
   assign state_d      = state_next;

   // Reset clears to zero, which is the FETCH encoding
   flopr #(.WIDTH(SW)) state_reg (
      .clk   (clk),
      .reset (reset),
      .d     (state_d),
      .q     (state_q)
   );

   assign state = statetype'(state_q);

   always_comb begin
      state_next = FETCH;
      case (state)
         FETCH:  state_next = MemRdy ? DECODE : FETCH;
         DECODE: begin
            case (Op)
               OP_MEM:  state_next = MEMADR;
               OP_DP:   state_next = Funct[5] ? EXECI : EXECR;
               OP_B:    state_next = BRANCH;
               default: state_next = UNDEF;
            endcase
         end
         MEMADR: state_next = Funct[0] ? MEMRD : MEMWR;
         MEMRD:  state_next = MemRdy ? MEMWB : MEMRD;
         MEMWR:  state_next = MemRdy ? FETCH : MEMWR;
         EXECR:  state_next = ALUWB;
         EXECI:  state_next = ALUWB;
         default: state_next = FETCH;
      endcase
   end

   mainfsm_dec dec (
      .state (state),
      .ctrl  (ctrl)
   );

   // Enables and write requests drop combinationally while reset is high
   assign IRWrite   = ctrl.fetch & MemRdy & ~reset;
   assign NextPC    = ctrl.fetch & MemRdy & ~reset;
   assign RegW      = ctrl.reg_w  & ~reset;
   assign MemW      = ctrl.mem_w  & ~reset;
   assign Branch    = ctrl.branch & ~reset;
   assign Undef     = ctrl.undef  & ~reset;
   assign AdrSrc    = ctrl.adr_src;
   assign ALUSrcA   = ctrl.alu_src_a;
   assign ALUSrcB   = ctrl.alu_src_b;
   assign ResultSrc = ctrl.result_src;
   assign ALUOp     = ctrl.alu_op;

endmodule

// File: tb/tb_mainfsm.sv
// Directed self-checking bench for mainfsm: per-cycle output
// vectors for each instruction class and reset cases.
module tb_mainfsm;

   logic       clk;
   logic       reset;
   logic [1:0] Op;
   logic [5:0] Funct;
   logic       MemRdy;
   logic       IRWrite, NextPC, AdrSrc, ALUSrcA;
   logic [1:0] ALUSrcB, ResultSrc;
   logic       ALUOp, RegW, MemW, Branch, Undef;

   int tests;
   int fails;

   // {IRWrite,NextPC,AdrSrc,ALUSrcA,ALUSrcB,ResultSrc,
   //  ALUOp,RegW,MemW,Branch,Undef}
   localparam logic [12:0] E_FETCH1 = 13'b1_1_0_1_10_10_0_0_0_0_0;
   localparam logic [12:0] E_FETCH0 = 13'b0_0_0_1_10_10_0_0_0_0_0;
   localparam logic [12:0] E_DECODE = 13'b0_0_0_1_10_10_0_0_0_0_0;
   localparam logic [12:0] E_MEMADR = 13'b0_0_0_0_01_00_0_0_0_0_0;
   localparam logic [12:0] E_EXECI  = 13'b0_0_0_0_01_00_1_0_0_0_0;
   localparam logic [12:0] E_EXECR  = 13'b0_0_0_0_00_00_1_0_0_0_0;
   localparam logic [12:0] E_MEMRD  = 13'b0_0_1_0_00_00_0_0_0_0_0;
   localparam logic [12:0] E_MEMWR  = 13'b0_0_1_0_00_00_0_0_1_0_0;
   localparam logic [12:0] E_MEMWRR = 13'b0_0_1_0_00_00_0_0_0_0_0;
   localparam logic [12:0] E_MEMWB  = 13'b0_0_0_0_00_01_0_1_0_0_0;
   localparam logic [12:0] E_ALUWB  = 13'b0_0_0_0_00_00_0_1_0_0_0;
   localparam logic [12:0] E_BRANCH = 13'b0_0_0_0_01_10_0_0_0_1_0;
   localparam logic [12:0] E_UNDEF  = 13'b0_0_0_0_00_00_0_0_0_0_1;

   logic [12:0] obs;
   assign obs = {IRWrite, NextPC, AdrSrc, ALUSrcA, ALUSrcB,
                 ResultSrc, ALUOp, RegW, MemW, Branch, Undef};

   mainfsm dut (
      .clk       (clk),
      .reset     (reset),
      .Op        (Op),
      .Funct     (Funct),
      .MemRdy    (MemRdy),
      .IRWrite   (IRWrite),
      .NextPC    (NextPC),
      .AdrSrc    (AdrSrc),
      .ALUSrcA   (ALUSrcA),
      .ALUSrcB   (ALUSrcB),
      .ResultSrc (ResultSrc),
      .ALUOp     (ALUOp),
      .RegW      (RegW),
      .MemW      (MemW),
      .Branch    (Branch),
      .Undef     (Undef)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      reset  = 1'b1;
      MemRdy = 1'b1;
      Op     = 2'b00;
      Funct  = 6'b000000;
      next_cycle();
      @(negedge clk);
      tests++;
      if (obs !== E_FETCH0) begin
         fails++;
         $display("FAIL reset_hold got=%b exp=%b", obs, E_FETCH0);
      end
      next_cycle();
      reset = 1'b0;
      @(negedge clk);
      tests++;
      if (obs !== E_FETCH1) begin
         fails++;
         $display("FAIL reset_release got=%b exp=%b", obs, E_FETCH1);
      end
      MemRdy = 1'b0;
      next_cycle();
   endtask

   task automatic test_dp_reg();
      logic [12:0] ex [5] = '{E_FETCH1, E_DECODE, E_EXECR,
                              E_ALUWB, E_FETCH0};
      logic        mr [5] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
      Op    = 2'b00;
      Funct = 6'b000000;
      for (int i = 0; i < 5; i++) begin
         MemRdy = mr[i];
         @(negedge clk);
         tests++;
         if (obs !== ex[i]) begin
            fails++;
            $display("FAIL dp_reg c%0d got=%b exp=%b", i, obs, ex[i]);
         end
         next_cycle();
      end
   endtask

   task automatic test_dp_imm();
      logic [12:0] ex [5] = '{E_FETCH1, E_DECODE, E_EXECI,
                              E_ALUWB, E_FETCH0};
      logic        mr [5] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
      Op    = 2'b00;
      Funct = 6'b100000;
      for (int i = 0; i < 5; i++) begin
         MemRdy = mr[i];
         @(negedge clk);
         tests++;
         if (obs !== ex[i]) begin
            fails++;
            $display("FAIL dp_imm c%0d got=%b exp=%b", i, obs, ex[i]);
         end
         next_cycle();
      end
   endtask

   task automatic test_load_stall();
      logic [12:0] ex [8] = '{E_FETCH1, E_DECODE, E_MEMADR, E_MEMRD,
                              E_MEMRD, E_MEMRD, E_MEMWB, E_FETCH0};
      logic        mr [8] = '{1'b1, 1'b0, 1'b0, 1'b0,
                              1'b0, 1'b1, 1'b0, 1'b0};
      Op    = 2'b01;
      Funct = 6'b000001;
      for (int i = 0; i < 8; i++) begin
         MemRdy = mr[i];
         @(negedge clk);
         tests++;
         if (obs !== ex[i]) begin
            fails++;
            $display("FAIL load c%0d got=%b exp=%b", i, obs, ex[i]);
         end
         next_cycle();
      end
   endtask

   task automatic test_store();
      logic [12:0] ex [5] = '{E_FETCH1, E_DECODE, E_MEMADR,
                              E_MEMWR, E_FETCH0};
      logic        mr [5] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
      Op    = 2'b01;
      Funct = 6'b000000;
      for (int i = 0; i < 5; i++) begin
         MemRdy = mr[i];
         @(negedge clk);
         tests++;
         if (obs !== ex[i]) begin
            fails++;
            $display("FAIL store c%0d got=%b exp=%b", i, obs, ex[i]);
         end
         next_cycle();
      end
   endtask

   task automatic test_branch();
      logic [12:0] ex [4] = '{E_FETCH1, E_DECODE, E_BRANCH, E_FETCH0};
      logic        mr [4] = '{1'b1, 1'b1, 1'b1, 1'b0};
      Op    = 2'b10;
      Funct = 6'b111111;
      for (int i = 0; i < 4; i++) begin
         MemRdy = mr[i];
         @(negedge clk);
         tests++;
         if (obs !== ex[i]) begin
            fails++;
            $display("FAIL branch c%0d got=%b exp=%b", i, obs, ex[i]);
         end
         next_cycle();
      end
   endtask

   task automatic test_undef();
      logic [12:0] ex [4] = '{E_FETCH1, E_DECODE, E_UNDEF, E_FETCH0};
      logic        mr [4] = '{1'b1, 1'b1, 1'b1, 1'b0};
      Op    = 2'b11;
      Funct = 6'b000001;
      for (int i = 0; i < 4; i++) begin
         MemRdy = mr[i];
         @(negedge clk);
         tests++;
         if (obs !== ex[i]) begin
            fails++;
            $display("FAIL undef c%0d got=%b exp=%b", i, obs, ex[i]);
         end
         next_cycle();
      end
   endtask

   task automatic test_reset_in_memwr();
      logic [12:0] ex [7] = '{E_FETCH1, E_DECODE, E_MEMADR, E_MEMWR,
                              E_MEMWRR, E_FETCH0, E_FETCH1};
      logic        mr [7] = '{1'b1, 1'b0, 1'b0, 1'b0,
                              1'b0, 1'b1, 1'b1};
      logic        rs [7] = '{1'b0, 1'b0, 1'b0, 1'b0,
                              1'b1, 1'b1, 1'b0};
      Op    = 2'b01;
      Funct = 6'b000000;
      for (int i = 0; i < 7; i++) begin
         MemRdy = mr[i];
         reset  = rs[i];
         @(negedge clk);
         tests++;
         if (obs !== ex[i]) begin
            fails++;
            $display("FAIL rst_memwr c%0d got=%b exp=%b",
                     i, obs, ex[i]);
         end
         next_cycle();
      end
      reset  = 1'b0;
      MemRdy = 1'b0;
      @(negedge clk);
      tests++;
      if (obs !== E_DECODE) begin
         fails++;
         $display("FAIL rst_memwr_after got=%b exp=%b", obs, E_DECODE);
      end
      next_cycle();
   endtask

   initial begin
      tests = 0;
      fails = 0;
      test_reset();
      test_dp_reg();
      test_dp_imm();
      test_load_stall();
      test_store();
      test_branch();
      test_undef();
      test_reset_in_memwr();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
